// File: rtl/pad_status_tx.sv
// pad_status_tx: snapshots pad config/inputs and streams a 5-byte 8N1 UART status frame.
// Define PAD_STATUS_TX_PARITY_EN to add an even-parity bit per byte (8E1).
module pad_status_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        auto_en,
  input  logic [17:0] pad_config,
  input  logic [3:0]  pad_in,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  byte_idx
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
`ifdef PAD_STATUS_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;
`endif
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [17:0]   cfg_q, cfg_d;
  logic [3:0]    pin_q, pin_d;
  logic          done_q, done_d;
  logic          tick;
  logic [7:0]    b1, b2, b3, cur;
  assign tick = baud_q == BAUD_MAX;
  assign b1 = cfg_q[7:0];
  assign b2 = cfg_q[15:8];
  assign b3 = {2'b00, pin_q, cfg_q[17:16]};
  assign cur = (byte_q == 3'd0) ? SYNC_BYTE :
               (byte_q == 3'd1) ? b1 :
               (byte_q == 3'd2) ? b2 :
               (byte_q == 3'd3) ? b3 : SYNC_BYTE ^ b1 ^ b2 ^ b3;
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    cfg_d   = cfg_q;
    pin_d   = pin_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start || auto_en) begin
        state_d = START_BIT;
        cfg_d   = pad_config;
        pin_d   = pad_in;
        byte_d  = '0;
        bit_d   = '0;
      end
      START_BIT: if (tick) state_d = DATA_BITS;
      DATA_BITS: if (tick) begin
        bit_d = bit_q + 3'd1;
`ifdef PAD_STATUS_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY_BIT;
`else
        if (bit_q == 3'd7) state_d = STOP_BIT;
`endif
      end
`ifdef PAD_STATUS_TX_PARITY_EN
      PARITY_BIT: if (tick) state_d = STOP_BIT;
`endif
      STOP_BIT: if (tick) begin
        // next byte's start bit follows the stop bit with no gap
        state_d = (byte_q == 3'd4) ? IDLE : START_BIT;
        byte_d  = (byte_q == 3'd4) ? 3'd0 : byte_q + 3'd1;
        done_d  = byte_q == 3'd4;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tx = 1'b1;
    if (state_q == START_BIT) tx = 1'b0;
    if (state_q == DATA_BITS) tx = cur[bit_q];
`ifdef PAD_STATUS_TX_PARITY_EN
    if (state_q == PARITY_BIT) tx = ^cur;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      cfg_q   <= '0;
      pin_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      cfg_q   <= cfg_d;
      pin_q   <= pin_d;
      done_q  <= done_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign frame_done = done_q;
  assign byte_idx   = byte_q;
endmodule

// File: tb/tb_pad_status_tx.sv
// tb_pad_status_tx: table-driven and random frames checked against a bit-stream model of the UART frame.
module tb_pad_status_tx;
  localparam int C = 4;
`ifdef PAD_STATUS_TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int FLEN = 5 * BITS * C;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, auto_en = 1'b0;
  logic [17:0] pad_config = '0;
  logic [3:0] pad_in = '0;
  logic tx, busy, frame_done;
  logic [2:0] byte_idx;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pad_status_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en),
    .pad_config(pad_config), .pad_in(pad_in),
    .tx(tx), .busy(busy), .frame_done(frame_done), .byte_idx(byte_idx)
  );
  typedef struct {
    logic [17:0] cfg;
    logic [3:0]  pin;
    bit          both;
    bit          corrupt;
    logic [39:0] exp;
  } vec_t;
  vec_t v[4];
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  // frame bytes packed as {b4,b3,b2,b1,b0}
  function automatic logic [39:0] model(input logic [17:0] c, input logic [3:0] p);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'hA5;
    b1 = c[7:0];
    b2 = c[15:8];
    b3 = {2'b00, p, c[17:16]};
    return {b0 ^ b1 ^ b2 ^ b3, b3, b2, b1, b0};
  endfunction
  function automatic logic line_at(input logic [39:0] f, input int t);
    int k, s;
    logic [7:0] b;
    k = t / (BITS * C);
    s = (t / C) % BITS;
    b = f[k*8 +: 8];
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (BITS == 11 && s == 9) return ^b;
    return 1'b1;
  endfunction
  task automatic kick(input logic [17:0] cfg, input logic [3:0] pin, input bit both, input bit corrupt);
    pad_config = cfg;
    pad_in = pin;
    start = 1'b1;
    auto_en = both;
    @(negedge clk);
    start = 1'b0;
    auto_en = 1'b0;
    if (corrupt) begin
      pad_config = '0;
      pad_in = ~pin;
    end
  endtask
  task automatic run_frame(input string tag, input logic [39:0] req, input int pulse_at, input bit keep_auto);
    logic [39:0] got;
    int blen, bad, idxbad, k, s;
    got = '0;
    blen = 0;
    bad = 0;
    idxbad = 0;
    while (busy === 1'b1 && blen < FLEN + 8) begin
      if (blen < FLEN) begin
        k = blen / (BITS * C);
        s = (blen / C) % BITS;
        if (tx !== line_at(req, blen)) bad++;
        if (byte_idx !== 3'(k)) idxbad++;
        if (blen % C == C / 2 && s >= 1 && s <= 8) got[k*8 + s - 1] = tx;
      end
      start = (pulse_at >= 0 && blen == pulse_at);
      blen++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy_len"}, blen, FLEN);
    chk({tag, " bytes"}, got, req);
    chk({tag, " line_mismatch_cycles"}, bad, 0);
    chk({tag, " byte_idx_errs"}, idxbad, 0);
    chk({tag, " frame_done"}, frame_done, 1);
    chk({tag, " tx_idle"}, tx, 1);
    chk({tag, " idx_idle"}, byte_idx, 0);
    if (!keep_auto) begin
      @(negedge clk);
      chk({tag, " done_one_cycle"}, frame_done, 0);
      chk({tag, " no_restart"}, busy, 0);
    end
  endtask
  initial begin
    logic [17:0] rc;
    logic [3:0] rp;
    v[0] = '{18'h1A5C3, 4'b1010, 1'b0, 1'b0, 40'hEA29A5C3A5};
    v[1] = '{18'h1A5C3, 4'b1010, 1'b0, 1'b1, 40'hEA29A5C3A5};
    v[2] = '{18'h3FFFF, 4'hF,    1'b1, 1'b0, 40'h9A3FFFFFA5};
    v[3] = '{18'h00000, 4'h0,    1'b0, 1'b0, 40'hA5000000A5};
    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset byte_idx", byte_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      kick(v[i].cfg, v[i].pin, v[i].both, v[i].corrupt);
      run_frame($sformatf("vec%0d", i), v[i].exp, -1, 1'b0);
    end
    for (int r = 0; r < 6; r++) begin
      rc = 18'($urandom);
      rp = 4'($urandom);
      kick(rc, rp, 1'b0, r[0]);
      run_frame($sformatf("rand%0d", r), model(rc, rp), -1, 1'b0);
    end
    kick(18'h1A5C3, 4'b1010, 1'b0, 1'b0);
    run_frame("ignored_start", 40'hEA29A5C3A5, BITS * C + 5, 1'b0);
    repeat (C) @(negedge clk);
    chk("ignored_start idle_after", busy, 0);
    pad_config = 18'h1A5C3;
    pad_in = 4'b1010;
    auto_en = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      run_frame($sformatf("auto%0d", f), 40'hEA29A5C3A5, -1, 1'b1);
      if (f == 2) auto_en = 1'b0;
      @(negedge clk);
    end
    chk("auto stop busy", busy, 0);
    chk("auto stop frame_done", frame_done, 0);
    kick(18'h1A5C3, 4'b1010, 1'b0, 1'b0);
    repeat (2 * BITS * C + 4 * C) @(negedge clk);
    chk("midreset byte_idx_before", byte_idx, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset tx", tx, 1);
    chk("midreset busy", busy, 0);
    chk("midreset byte_idx", byte_idx, 0);
    chk("midreset frame_done", frame_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    kick(18'h1A5C3, 4'b1010, 1'b0, 1'b0);
    run_frame("after_reset", 40'hEA29A5C3A5, -1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pad_status_tx.md
Name: pad_status_tx

Overview:
- Serial status transmitter: the readback direction for the pad-configuration path.
- Snapshots the 18-bit pad configuration word and the 4 pad input levels, then streams them as a fixed 5-byte UART frame (8N1, LSB first) on one output pin.
- A bench or host logger can capture the live pad state without decoding the parallel debug outputs.
- Sits beside the pad config register in the pad-test top; tx drives one dedicated output.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range 2..65535.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  request one frame; sampled only in IDLE
- auto_en  input  1  level; while high, a new frame starts automatically on every IDLE cycle
- pad_config  input  18  live pad configuration word
- pad_in  input  4  live pad input levels
- tx  output  1  UART serial line, idle high
- busy  output  1  high from frame start until the end of the final stop bit
- frame_done  output  1  one-cycle pulse on the cycle that returns to IDLE after the last stop bit
- byte_idx  output  3  index of the byte being sent (0..4); 0 in IDLE

Behaviour:
- Reset (rst_n low at a clk edge, any state, including mid-frame):
  - outputs: tx=1, busy=0, frame_done=0, byte_idx=0
  - internal: state=IDLE; bit counter, baud counter and snapshot cleared
- States: IDLE, START_BIT, DATA_BITS, [PARITY_BIT], STOP_BIT.
- IDLE:
  - If start or auto_en is high at edge N: capture snapshot, load byte 0, enter START_BIT.
  - From cycle N+1: tx=0, busy=1.
  - start pulses while busy are ignored, not queued.
- Snapshot:
  - pad_config and pad_in are registered once at frame start.
  - Input changes during a frame do not affect it.
- Frame bytes:
  - b0 = SYNC_BYTE
  - b1 = cfg[7:0]
  - b2 = cfg[15:8]
  - b3 = {2'b00, pad_in[3:0], cfg[17:16]}
  - b4 = b0^b1^b2^b3
- Bit timing:
  - Each bit holds tx for exactly CLKS_PER_BIT cycles; the baud counter runs 0..CLKS_PER_BIT-1 and wraps.
  - Data bits are sent LSB first; the stop bit is tx=1.
- Byte sequencing:
  - After byte k's stop bit, k<4: the next start bit follows immediately (no gap), and byte_idx increments.
  - After byte 4's stop bit: go to IDLE; frame_done=1 for that one cycle; busy=0; tx=1.
- Frame length:
  - 50*CLKS_PER_BIT cycles (55*CLKS_PER_BIT with parity), measured from the first tx-low cycle to the first IDLE cycle.
- Back-to-back:
  - With auto_en held high, the next frame's start bit begins on the cycle after the frame_done cycle.
  - Line gap between frames: exactly 1 idle cycle beyond the stop bit.
- Simultaneous events:
  - start and auto_en both high: one frame only.
  - rst_n low has priority over everything.
- Counter widths: the baud counter is sized with $clog2(CLKS_PER_BIT); no overflow is permitted at the maximum parameter value.

Optional Feature:
- Macro: PAD_STATUS_TX_PARITY_EN.
- Defined:
  - A PARITY_BIT state is inserted between DATA_BITS and STOP_BIT.
  - tx = even parity (XOR of the 8 data bits), held for CLKS_PER_BIT cycles.
  - Each byte is 11 bit periods.
- Undefined: pure 8N1, no parity state or logic synthesized.

Test Plan:
- Setup: CLKS_PER_BIT=4, no parity, pad_config=18'h1A5C3, pad_in=4'b1010, one start pulse.
  - Required bytes: A5, C3, A5, 29, EA.
  - busy high for exactly 200 cycles; a single frame_done pulse; tx=1 afterward.
- Snapshot: change pad_config to 18'h00000 one cycle after start.
  - The frame still carries C3, A5, 29, EA.
- Back-to-back: auto_en held high for 3 frames.
  - Three identical frames.
  - Exactly one tx-high idle cycle between each frame's final stop bit and the next start bit.
  - byte_idx sequence 0..4 repeated.
- Reset mid-frame: assert rst_n=0 during byte 2, bit 3.
  - Next cycle: tx=1, busy=0, byte_idx=0.
  - A new start then produces a complete, correct frame.
- Ignored start: pulse start during byte 1.
  - Exactly one frame; no extra frame follows frame_done.
- PAD_STATUS_TX_PARITY_EN defined, same stimulus as the first setup:
  - Parity bits 0,0,0,1,1 for bytes A5, C3, A5, 29, EA.
  - busy high for 220 cycles.
